// File: rtl/serial_cmd_tx_if.sv
// Command handshake and serial line bundle between the input scanner and serial_cmd_tx.
// Latency: n/a (wires only).
// Backpressure: the master holds valid until it sees ready; commands offered while ready=0 are dropped.
interface serial_cmd_tx_if;
  logic       valid;
  logic       player;
  logic [1:0] pos;
  logic [1:0] door;
  logic       ready;
  logic       busy;
  logic       done;
  logic       serial_out;

  modport master (
    output valid, player, pos, door,
    input  ready, busy, done, serial_out
  );

  modport slave (
    input  valid, player, pos, door,
    output ready, busy, done, serial_out
  );
endinterface

// File: rtl/serial_cmd_tx.sv
// Sends one player move as an 8N1 two-byte frame (HEADER, then {3'b0,player,pos,door}), LSB first.
// Latency: start bit begins the cycle after accept; a frame is 20*CLKS_PER_BIT cycles, with done in the following cycle.
// Backpressure: ready is low for the whole frame; valid is only sampled while ready=1 and is never queued.
module serial_cmd_tx #(
  parameter int         CLKS_PER_BIT = 217,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic           clk,
  input  logic           reset,
  serial_cmd_tx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             byte_idx;
  logic [7:0]       shift;
  logic [7:0]       payload;
  logic             ser_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  wire bit_end = (baud_cnt == CNT_MAX);

  // Frame sequencer: every output is registered, and the line level for the
  // next bit is loaded on the same edge that changes state so it never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= 1'b0;
      shift    <= '0;
      payload  <= '0;
      ser_q    <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (bus.valid) begin
            shift    <= HEADER;
            payload  <= {3'b000, bus.player, bus.pos, bus.door};
            byte_idx <= 1'b0;
            state    <= START;
            ser_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            ser_q    <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
              ser_q <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // shift[1] becomes shift[0] on this same edge
              ser_q   <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!byte_idx) begin
              // header done: payload follows with no gap
              shift    <= payload;
              byte_idx <= 1'b1;
              state    <= START;
              ser_q    <= 1'b0;
            end else begin
              state   <= IDLE;
              ser_q   <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          ser_q    <= 1'b1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.serial_out = ser_q;
  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_serial_cmd_tx.sv
// Self-checking bench for serial_cmd_tx at CLKS_PER_BIT=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_cmd_tx;

  localparam int         CPB = 4;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int         NS  = 300;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic s_ser  [NS];
  logic s_done [NS];
  logic s_rdy  [NS];
  logic s_busy [NS];

  serial_cmd_tx_if bus ();

  serial_cmd_tx #(.CLKS_PER_BIT(CPB), .HEADER(HDR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: payload byte from the move fields, by plain arithmetic.
  function automatic logic [7:0] payload_of(input logic p, input logic [1:0] ps, input logic [1:0] d);
    int v;
    v = int'(p) * 16 + int'(ps) * 4 + int'(d);
    return v[7:0];
  endfunction

  // Reference: level of frame bit i (0..19) for an 8N1 two-byte frame.
  function automatic logic exp_bit(input logic [7:0] h, input logic [7:0] pl, input int i);
    int   j;
    int   byv;
    j   = i % 10;
    byv = (i < 10) ? int'(h) : int'(pl);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return ((byv >> (j - 1)) & 1) != 0;
  endfunction

  task automatic start_cmd(input logic p, input logic [1:0] ps, input logic [1:0] d);
    bus.player = p;
    bus.pos    = ps;
    bus.door   = d;
    bus.valid  = 1'b1;
  endtask

  // Records n cycles of outputs; sample 0 is the cycle after the next rising edge.
  task automatic record(input int n, input int drop_valid_at, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_ser[i]  = bus.serial_out;
      s_done[i] = bus.done;
      s_rdy[i]  = bus.ready;
      s_busy[i] = bus.busy;
      if (i >= drop_valid_at) begin
        bus.valid = 1'b0;
      end else if (rnd) begin
        bus.valid  = 1'($urandom);
        bus.player = 1'($urandom);
        bus.pos    = 2'($urandom);
        bus.door   = 2'($urandom);
      end
    end
  endtask

  // Behavioural UART receiver over the recorded line: find start edge, sample mid-bit.
  task automatic uart_rx(input int from, input int lim, output logic [7:0] b, output bit ok, output int nxt);
    int p;
    int mid;
    p   = from;
    b   = 8'h00;
    ok  = 1'b0;
    nxt = lim;
    while (p < lim && s_ser[p] !== 1'b0) p++;
    if (p + 10 * CPB <= lim) begin
      mid = p + CPB / 2;
      ok  = (s_ser[mid] === 1'b0) && (s_ser[mid + 9 * CPB] === 1'b1);
      for (int k = 0; k < 8; k++) b[k] = s_ser[mid + (k + 1) * CPB];
      nxt = p + 10 * CPB;
    end
  endtask

  task automatic count_done(input int n, output int cnt, output int first);
    cnt   = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      if (s_done[i] === 1'b1) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] obs;
    bit         bad;
    reset     = 1'b0;
    bus.valid = 1'b0;
    bus.player = 1'b0;
    bus.pos   = 2'd0;
    bus.door  = 2'd0;
    bad = 1'b0;
    obs = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({bus.serial_out, bus.ready, bus.busy, bus.done} !== 4'b1100) begin
        bad = 1'b1;
        obs = {bus.serial_out, bus.ready, bus.busy, bus.done};
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_hold: {ser,rdy,busy,done}=%b expected 1100", obs);
    end
    reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({bus.serial_out, bus.ready, bus.busy, bus.done} !== 4'b1100) begin
        bad = 1'b1;
        obs = {bus.serial_out, bus.ready, bus.busy, bus.done};
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle_after_reset: {ser,rdy,busy,done}=%b expected 1100", obs);
    end
  endtask

  task automatic test_single_frame;
    logic [7:0] pl;
    int         cnt;
    int         first;
    bit         ok;
    pl = payload_of(1'b1, 2'd2, 2'd3);
    start_cmd(1'b1, 2'd2, 2'd3);
    record(90, 0, 1'b0);
    for (int b = 0; b < 20; b++) begin
      ok = 1'b1;
      for (int c = 0; c < CPB; c++)
        if (s_ser[b * CPB + c] !== exp_bit(HDR, pl, b)) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL single_bit%0d: samples %b%b%b%b expected all %b", b,
                 s_ser[b*CPB], s_ser[b*CPB+1], s_ser[b*CPB+2], s_ser[b*CPB+3], exp_bit(HDR, pl, b));
      end
    end
    count_done(90, cnt, first);
    checks++;
    if (cnt !== 1 || first !== 20 * CPB) begin
      errors++;
      $display("FAIL single_done: count=%0d at=%0d expected count=1 at=%0d", cnt, first, 20 * CPB);
    end
    checks++;
    if (s_rdy[20*CPB] !== 1'b1 || s_busy[20*CPB] !== 1'b0 || s_rdy[20*CPB-1] !== 1'b0 || s_rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: rdy[0]=%b rdy[79]=%b rdy[80]=%b busy[80]=%b expected 0,0,1,0",
               s_rdy[0], s_rdy[20*CPB-1], s_rdy[20*CPB], s_busy[20*CPB]);
    end
    ok = 1'b1;
    for (int i = 0; i < 90; i++) if (s_busy[i] !== ~s_rdy[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_vs_ready: busy not always ~ready (got mismatch) expected complement");
    end
  endtask

  task automatic test_input_isolation;
    logic [7:0] b0;
    logic [7:0] b1;
    bit         ok0;
    bit         ok1;
    int         nxt;
    int         cnt;
    int         first;
    start_cmd(1'b0, 2'd1, 2'd0);
    record(100, 20 * CPB - 2, 1'b1);
    uart_rx(0, 100, b0, ok0, nxt);
    uart_rx(nxt, 100, b1, ok1, nxt);
    checks++;
    if (!ok0 || !ok1 || b0 !== HDR || b1 !== payload_of(1'b0, 2'd1, 2'd0)) begin
      errors++;
      $display("FAIL isolation_payload: hdr=%h pay=%h framing=%b%b expected hdr=%h pay=%h framing=11",
               b0, b1, ok0, ok1, HDR, payload_of(1'b0, 2'd1, 2'd0));
    end
    count_done(100, cnt, first);
    checks++;
    if (cnt !== 1 || first !== 20 * CPB) begin
      errors++;
      $display("FAIL isolation_done: count=%0d at=%0d expected count=1 at=%0d", cnt, first, 20 * CPB);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pl;
    int         cnt;
    int         first;
    bit         ok;
    int         per;
    per = 20 * CPB + 1;
    pl  = payload_of(1'b1, 2'd0, 2'd2);
    start_cmd(1'b1, 2'd0, 2'd2);
    record(260, 200, 1'b0);
    for (int k = 0; k < 3; k++) begin
      ok = 1'b1;
      for (int i = 0; i < 20 * CPB; i++)
        if (s_ser[k * per + i] !== exp_bit(HDR, pl, i / CPB)) ok = 1'b0;
      if (k > 0 && s_ser[k * per - 1] !== 1'b1) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b_frame%0d: start at %0d ser=%b, bit pattern differs expected start=0 at %0d",
                 k, k * per, s_ser[k * per], k * per);
      end
    end
    count_done(260, cnt, first);
    checks++;
    if (cnt !== 3 || first !== 20 * CPB || s_done[per + 20*CPB] !== 1'b1 || s_done[2*per + 20*CPB] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: count=%0d first=%0d expected count=3 at %0d,%0d,%0d",
               cnt, first, 20 * CPB, per + 20 * CPB, 2 * per + 20 * CPB);
    end
    ok = 1'b1;
    for (int i = 3 * per; i < 260; i++) if (s_ser[i] !== 1'b1 || s_rdy[i] !== 1'b1) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_tail: line or ready dropped after third frame, expected idle high/ready");
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] obs;
    logic [7:0] b0;
    logic [7:0] b1;
    bit         ok0;
    bit         ok1;
    bit         bad;
    int         nxt;
    int         cnt;
    int         first;
    start_cmd(1'b1, 2'd1, 2'd1);
    // payload bit 3 is frame bit 14, cycles 56..59
    record(14 * CPB + 2, 0, 1'b0);
    #2 reset = 1'b0;
    #1;
    obs = {bus.serial_out, bus.ready, bus.busy, bus.done};
    checks++;
    if (obs !== 4'b1100) begin
      errors++;
      $display("FAIL midreset_async: {ser,rdy,busy,done}=%b expected 1100", obs);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.serial_out !== 1'b1) bad = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    if ({bus.serial_out, bus.ready, bus.busy, bus.done} !== 4'b1100) bad = 1'b1;
    obs = {bus.serial_out, bus.ready, bus.busy, bus.done};
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midreset_release: {ser,rdy,busy,done}=%b after release, expected 1100 and no done", obs);
    end
    start_cmd(1'b0, 2'd3, 2'd1);
    record(90, 0, 1'b0);
    uart_rx(0, 90, b0, ok0, nxt);
    uart_rx(nxt, 90, b1, ok1, nxt);
    count_done(90, cnt, first);
    checks++;
    if (!ok0 || !ok1 || b0 !== HDR || b1 !== payload_of(1'b0, 2'd3, 2'd1) || cnt !== 1 || first !== 20 * CPB) begin
      errors++;
      $display("FAIL midreset_next: hdr=%h pay=%h framing=%b%b done=%0d@%0d expected %h %h 11 1@%0d",
               b0, b1, ok0, ok1, cnt, first, HDR, payload_of(1'b0, 2'd3, 2'd1), 20 * CPB);
    end
  endtask

  task automatic test_boundary_payload;
    logic [7:0] b0;
    logic [7:0] b1;
    bit         ok0;
    bit         ok1;
    int         nxt;
    logic [7:0] exp;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        start_cmd(1'b1, 2'd3, 2'd3);
        exp = payload_of(1'b1, 2'd3, 2'd3);
      end else begin
        start_cmd(1'b0, 2'd0, 2'd0);
        exp = payload_of(1'b0, 2'd0, 2'd0);
      end
      record(85, 0, 1'b0);
      uart_rx(0, 85, b0, ok0, nxt);
      uart_rx(nxt, 85, b1, ok1, nxt);
      checks++;
      if (!ok0 || !ok1 || b0 !== HDR || b1 !== exp) begin
        errors++;
        $display("FAIL boundary%0d: hdr=%h pay=%h framing=%b%b expected %h %h 11", t, b0, b1, ok0, ok1, HDR, exp);
      end
    end
  endtask

  task automatic test_random_frames;
    logic       p;
    logic [1:0] ps;
    logic [1:0] d;
    logic [7:0] b0;
    logic [7:0] b1;
    bit         ok0;
    bit         ok1;
    int         nxt;
    for (int t = 0; t < 4; t++) begin
      p  = 1'($urandom);
      ps = 2'($urandom_range(3, 0));
      d  = 2'($urandom_range(3, 0));
      start_cmd(p, ps, d);
      record(85, 0, 1'b0);
      uart_rx(0, 85, b0, ok0, nxt);
      uart_rx(nxt, 85, b1, ok1, nxt);
      checks++;
      if (!ok0 || !ok1 || b0 !== HDR || b1 !== payload_of(p, ps, d)) begin
        errors++;
        $display("FAIL random%0d: hdr=%h pay=%h framing=%b%b expected %h %h 11",
                 t, b0, b1, ok0, ok1, HDR, payload_of(p, ps, d));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.valid  = 1'b0;
    bus.player = 1'b0;
    bus.pos    = 2'd0;
    bus.door   = 2'd0;
    test_reset();
    test_single_frame();
    test_input_isolation();
    test_back_to_back();
    test_reset_mid_frame();
    test_boundary_payload();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
